// File: rtl/uart_bus_pkg.sv
// uart_bus_pkg: register map, STATUS/CTRL bit indices and TX FSM encoding for uart_bus_ctrl
package uart_bus_pkg;
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL = 2'd2;
  localparam int ST_RX_NEMPTY = 0;
  localparam int ST_TX_FULL = 1;
  localparam int ST_TX_IDLE = 2;
  localparam int ST_RX_OVR = 3;
  localparam int ST_TX_OVF = 4;
  localparam int CTRL_RX_IRQ_EN = 0;
  localparam int CTRL_TX_IRQ_EN = 1;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_WAIT_BUSY, TX_WAIT_DONE} tx_state_e;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: show-ahead FIFO (clk, rst async active-low, push/din, pop/dout, full/empty); a pop lets a push into a full FIFO
module uart_sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp_q, rp_q;
  logic do_pop, do_push;
  assign empty = wp_q == rp_q;
  assign full = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout = mem[rp_q[AW-1:0]];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= do_push ? wp_q + 1'b1 : wp_q;
      rp_q <= do_pop ? rp_q + 1'b1 : rp_q;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wp_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/uart_bus_ctrl.sv
// uart_bus_ctrl: bus-mapped UART front end (bus_* CPU port, uart_* core port, irq) with TX/RX FIFOs and start-strobe FSM
module uart_bus_ctrl
  import uart_bus_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW = 4,
  parameter int TX_BUSY_TO = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bus_cs,
  input  logic       bus_we,
  input  logic [1:0] bus_addr,
  input  logic [7:0] bus_wdata,
  output logic [7:0] bus_rdata,
  output logic       bus_ack,
  output logic       irq,
  output logic [7:0] uart_data_out,
  output logic       uart_tx_start_n,
  input  logic       uart_tx_busy,
  input  logic [7:0] uart_rx_data,
  input  logic       uart_rx_ready
);
  localparam int CW = $clog2(TX_BUSY_TO + 1);
  tx_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] rdata_q, rdata_d, data_out_q, status, tx_dout, rx_dout;
  logic [1:0] ctrl_q;
  logic ack_q, irq_q, tx_ovf_q, rx_ovr_q, rx_rdy_q;
  logic rd, wr, tx_push, tx_pop, rx_push, rx_pop, stat_clr, tx_idle;
  logic tx_full, tx_empty, rx_full, rx_empty;
  assign rd = bus_cs & ~bus_we;
  assign wr = bus_cs & bus_we;
  assign tx_push = wr & (bus_addr == ADDR_DATA);
  assign rx_pop = rd & (bus_addr == ADDR_DATA);
  assign stat_clr = rd & (bus_addr == ADDR_STATUS);
  assign rx_push = uart_rx_ready & ~rx_rdy_q;
  assign tx_idle = tx_empty & (state_q == TX_IDLE) & ~uart_tx_busy;
  uart_sync_fifo #(.W(8), .DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .din(bus_wdata), .pop(tx_pop),
    .dout(tx_dout), .full(tx_full), .empty(tx_empty)
  );
  uart_sync_fifo #(.W(8), .DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .din(uart_rx_data), .pop(rx_pop),
    .dout(rx_dout), .full(rx_full), .empty(rx_empty)
  );
  always_comb begin
    state_d = state_q;
    tx_pop = 1'b0;
    cnt_d = '0;
    case (state_q)
      TX_IDLE: if (!tx_empty && !uart_tx_busy) begin
        state_d = TX_START;
        tx_pop = 1'b1;
      end
      TX_START: state_d = TX_WAIT_BUSY;
      TX_WAIT_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (uart_tx_busy || cnt_q == CW'(TX_BUSY_TO - 1)) state_d = TX_WAIT_DONE;
      end
      default: if (!uart_tx_busy) state_d = TX_IDLE;
    endcase
  end
  always_comb begin
    status = '0;
    status[ST_RX_NEMPTY] = ~rx_empty;
    status[ST_TX_FULL] = tx_full;
    status[ST_TX_IDLE] = tx_idle;
    status[ST_RX_OVR] = rx_ovr_q;
    status[ST_TX_OVF] = tx_ovf_q;
    rdata_d = !rd ? 8'h00 :
              bus_addr == ADDR_DATA ? (rx_empty ? 8'h00 : rx_dout) :
              bus_addr == ADDR_STATUS ? status :
              bus_addr == ADDR_CTRL ? {6'b0, ctrl_q} : 8'h00;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= TX_IDLE;
      cnt_q <= '0;
      rdata_q <= '0;
      ack_q <= 1'b0;
      irq_q <= 1'b0;
      ctrl_q <= '0;
      tx_ovf_q <= 1'b0;
      rx_ovr_q <= 1'b0;
      rx_rdy_q <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rdata_q <= rdata_d;
      ack_q <= bus_cs;
      irq_q <= (ctrl_q[CTRL_RX_IRQ_EN] & ~rx_empty) | (ctrl_q[CTRL_TX_IRQ_EN] & tx_idle);
      ctrl_q <= (wr && bus_addr == ADDR_CTRL) ? bus_wdata[1:0] : ctrl_q;
      tx_ovf_q <= (tx_push & tx_full & ~tx_pop) | (tx_ovf_q & ~stat_clr);
      rx_ovr_q <= (rx_push & rx_full & ~rx_pop) | (rx_ovr_q & ~stat_clr);
      rx_rdy_q <= uart_rx_ready;
      data_out_q <= tx_pop ? tx_dout : data_out_q;
    end
  end
  assign bus_rdata = rdata_q;
  assign bus_ack = ack_q;
  assign irq = irq_q;
  assign uart_data_out = data_out_q;
  assign uart_tx_start_n = state_q != TX_START;
endmodule

// File: tb/tb_uart_bus_ctrl.sv
// tb_uart_bus_ctrl: directed self-checking bench for uart_bus_ctrl
module tb_uart_bus_ctrl;
  logic clk, rst, bus_cs, bus_we, bus_ack, irq, uart_tx_start_n, uart_tx_busy, uart_rx_ready;
  logic [1:0] bus_addr;
  logic [7:0] bus_wdata, bus_rdata, uart_data_out, uart_rx_data, v;
  logic [7:0] first_d, last_d;
  logic prev_n;
  int total, passed, npulse, nlow, bcnt;
  uart_bus_ctrl dut (
    .clk(clk), .rst(rst), .bus_cs(bus_cs), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .irq(irq),
    .uart_data_out(uart_data_out), .uart_tx_start_n(uart_tx_start_n),
    .uart_tx_busy(uart_tx_busy), .uart_rx_data(uart_rx_data), .uart_rx_ready(uart_rx_ready)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
  endtask
  task automatic bus(input logic we, input logic [1:0] a, input logic [7:0] d);
    bus_cs = 1'b1;
    bus_we = we;
    bus_addr = a;
    bus_wdata = d;
    cyc();
    bus_cs = 1'b0;
    bus_we = 1'b0;
  endtask
  task automatic rd(input logic [1:0] a, output logic [7:0] r);
    bus(1'b0, a, 8'h00);
    r = bus_rdata;
  endtask
  task automatic rx_edge(input logic [7:0] d);
    uart_rx_data = d;
    uart_rx_ready = 1'b1;
    cyc();
    uart_rx_ready = 1'b0;
    cyc();
  endtask
  initial begin
    total = 0; passed = 0;
    rst = 1'b0; bus_cs = 1'b0; bus_we = 1'b0; bus_addr = 2'd0; bus_wdata = 8'h00;
    uart_tx_busy = 1'b0; uart_rx_data = 8'h00; uart_rx_ready = 1'b0;
    cyc(); cyc();
    chk("rst_rdata", bus_rdata, 8'h00);
    chk("rst_ack", {7'b0, bus_ack}, 8'h00);
    chk("rst_irq", {7'b0, irq}, 8'h00);
    chk("rst_data_out", uart_data_out, 8'h00);
    chk("rst_start_n", {7'b0, uart_tx_start_n}, 8'h01);
    rst = 1'b1;
    cyc();
    rd(2'd1, v); chk("status_after_rst", v, 8'h04);
    chk("read_ack", {7'b0, bus_ack}, 8'h01);
    cyc();
    chk("ack_one_cycle", {7'b0, bus_ack}, 8'h00);
    bus(1'b1, 2'd3, 8'hFF);
    chk("write_rdata_zero", bus_rdata, 8'h00);
    chk("write_ack", {7'b0, bus_ack}, 8'h01);
    rd(2'd3, v); chk("reserved_read", v, 8'h00);
    // two bytes, core busy 10 cycles per byte
    bus(1'b1, 2'd0, 8'h55);
    bus(1'b1, 2'd0, 8'hA3);
    npulse = 0; nlow = 0; bcnt = 0; prev_n = 1'b1; first_d = 8'h00; last_d = 8'h00;
    for (int c = 0; c < 100; c++) begin
      if (!uart_tx_start_n) begin
        nlow++;
        if (prev_n) begin
          npulse++;
          if (npulse == 1) first_d = uart_data_out;
          last_d = uart_data_out;
        end
        bcnt = 10;
      end
      prev_n = uart_tx_start_n;
      uart_tx_busy = bcnt > 0;
      if (bcnt > 0) bcnt--;
      cyc();
    end
    chk("tx_pulses", 8'(npulse), 8'd2);
    chk("tx_low_cycles", 8'(nlow), 8'd2);
    chk("tx_first_byte", first_d, 8'h55);
    chk("tx_second_byte", last_d, 8'hA3);
    chk("tx_data_held", uart_data_out, 8'hA3);
    rd(2'd1, v); chk("status_tx_done", v, 8'h04);
    // overflow with core stuck busy
    uart_tx_busy = 1'b1;
    for (int i = 0; i < 17; i++) bus(1'b1, 2'd0, 8'(8'h40 + i));
    rd(2'd1, v); chk("status_tx_ovf_full", v, 8'h12);
    rd(2'd1, v); chk("status_ovf_cleared", v, 8'h02);
    // drain via busy timeout, core never raises busy
    uart_tx_busy = 1'b0;
    npulse = 0; prev_n = 1'b1;
    for (int c = 0; c < 200; c++) begin
      cyc();
      if (!uart_tx_start_n && prev_n) begin
        npulse++;
        if (npulse == 1) first_d = uart_data_out;
        last_d = uart_data_out;
      end
      prev_n = uart_tx_start_n;
    end
    chk("timeout_pulses", 8'(npulse), 8'd16);
    chk("timeout_first", first_d, 8'h40);
    chk("timeout_last", last_d, 8'h4F);
    rd(2'd1, v); chk("status_drained", v, 8'h04);
    // rx level held 3 cycles pushes once
    bus(1'b1, 2'd2, 8'h01);
    rd(2'd2, v); chk("ctrl_readback", v, 8'h01);
    uart_rx_data = 8'h7E; uart_rx_ready = 1'b1;
    cyc(); cyc(); cyc();
    uart_rx_ready = 1'b0;
    cyc();
    chk("rx_irq_set", {7'b0, irq}, 8'h01);
    rd(2'd1, v); chk("status_rx_nempty", v, 8'h05);
    rd(2'd0, v); chk("rx_read_7e", v, 8'h7E);
    cyc();
    chk("rx_irq_clear", {7'b0, irq}, 8'h00);
    rd(2'd0, v); chk("rx_read_empty", v, 8'h00);
    bus(1'b1, 2'd2, 8'h00);
    // 17 edges: 16 stored, 17th lost
    for (int i = 0; i < 17; i++) rx_edge(8'(8'h20 + i));
    rd(2'd1, v); chk("status_rx_ovr", v, 8'h0D);
    rd(2'd1, v); chk("status_ovr_cleared", v, 8'h05);
    // pop and push together on a full FIFO
    uart_rx_data = 8'h99; uart_rx_ready = 1'b1;
    rd(2'd0, v); chk("rx_full_pop", v, 8'h20);
    uart_rx_ready = 1'b0;
    cyc();
    rd(2'd1, v); chk("status_no_ovr", v, 8'h05);
    for (int i = 0; i < 15; i++) begin
      rd(2'd0, v); chk("rx_order", v, 8'(8'h21 + i));
    end
    rd(2'd0, v); chk("rx_pushed_99", v, 8'h99);
    rd(2'd0, v); chk("rx_drained", v, 8'h00);
    // reset during TX_START
    uart_tx_busy = 1'b1;
    bus(1'b1, 2'd0, 8'hC3);
    bus(1'b1, 2'd0, 8'hC4);
    rx_edge(8'h11);
    uart_tx_busy = 1'b0;
    cyc();
    chk("start_before_rst", {7'b0, uart_tx_start_n}, 8'h00);
    chk("data_before_rst", uart_data_out, 8'hC3);
    rst = 1'b0;
    #1;
    chk("start_n_async_rst", {7'b0, uart_tx_start_n}, 8'h01);
    chk("data_out_async_rst", uart_data_out, 8'h00);
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    rd(2'd1, v); chk("status_after_abort", v, 8'h04);
    rd(2'd0, v); chk("rx_empty_after_rst", v, 8'h00);
    chk("no_tx_after_rst", {7'b0, uart_tx_start_n}, 8'h01);
    // tx idle interrupt
    bus(1'b1, 2'd2, 8'hFE);
    rd(2'd2, v); chk("ctrl_mask", v, 8'h02);
    chk("tx_irq", {7'b0, irq}, 8'h01);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
